// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencer that decodes a subset of 6502 ALU opcodes, fetches a
// zero-page operand when needed, drives an external ALU for ALU_LAT cycles
// and retires the result into the architectural A and P registers.
// Optional feature: define ALU_CTRL_ZP_EN to enable zero-page addressing
// (FETCH/WAIT states and the memory read port). Without it, zero-page
// opcodes are rejected as illegal and the memory port is tied off.
module alu_ctrl #(
  parameter int          ALU_LAT      = 1,
  parameter logic [7:0]  RESET_ACC    = 8'h00,
  parameter logic [7:0]  RESET_STATUS = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_opcode,
  input  logic [7:0] in_arg,
  output logic       mem_rd,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [3:0] alu_op,
  output logic [7:0] alu_acc,
  output logic [7:0] alu_operand,
  output logic [7:0] alu_status,
  input  logic [7:0] alu_result,
  input  logic [7:0] alu_status_in,
  output logic [7:0] acc_out,
  output logic [7:0] status_out,
  output logic       done,
  output logic       illegal
);

  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SBC  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_EOR  = 4'd4;
  localparam logic [3:0] OP_ORA  = 4'd5;
  localparam logic [3:0] OP_BIT  = 4'd6;
  localparam logic [3:0] OP_ASL  = 4'd7;
  localparam logic [3:0] OP_LSR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;
  localparam logic [3:0] OP_ROR  = 4'd10;
  localparam logic [3:0] OP_NONE = 4'hF;
  localparam int         CW      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

`ifdef ALU_CTRL_ZP_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, WB} state_t;
`else
  typedef enum logic [2:0] {IDLE, EXEC, WB} state_t;
`endif

  state_t        state, state_nx;
  logic [3:0]    op_q;
  logic [7:0]    opnd_q;
  logic [7:0]    acc, stat;
  logic          illegal_q;
  logic [CW-1:0] lat_cnt;
  logic          accept, exec_last;
  logic          dec_legal, dec_zp, dec_accm;
  logic [3:0]    dec_op;

  // Only IDLE offers in_ready, so acceptance is in_valid while idle.
  assign accept    = in_valid && (state == IDLE);
  assign exec_last = (state == EXEC) && (lat_cnt == CW'(ALU_LAT - 1));

  // Opcode decode: legality, addressing mode and ALU function.
  always_comb begin
    dec_legal = 1'b0;
    dec_zp    = 1'b0;
    dec_accm  = 1'b0;
    dec_op    = OP_NONE;
    case (in_opcode)
      8'h09: begin dec_legal = 1'b1; dec_op = OP_ORA; end
      8'h29: begin dec_legal = 1'b1; dec_op = OP_AND; end
      8'h49: begin dec_legal = 1'b1; dec_op = OP_EOR; end
      8'h69: begin dec_legal = 1'b1; dec_op = OP_ADC; end
      8'hE9: begin dec_legal = 1'b1; dec_op = OP_SBC; end
      8'h0A: begin dec_legal = 1'b1; dec_accm = 1'b1; dec_op = OP_ASL; end
      8'h2A: begin dec_legal = 1'b1; dec_accm = 1'b1; dec_op = OP_ROL; end
      8'h4A: begin dec_legal = 1'b1; dec_accm = 1'b1; dec_op = OP_LSR; end
      8'h6A: begin dec_legal = 1'b1; dec_accm = 1'b1; dec_op = OP_ROR; end
`ifdef ALU_CTRL_ZP_EN
      8'h05: begin dec_legal = 1'b1; dec_zp = 1'b1; dec_op = OP_ORA; end
      8'h25: begin dec_legal = 1'b1; dec_zp = 1'b1; dec_op = OP_AND; end
      8'h45: begin dec_legal = 1'b1; dec_zp = 1'b1; dec_op = OP_EOR; end
      8'h65: begin dec_legal = 1'b1; dec_zp = 1'b1; dec_op = OP_ADC; end
      8'hE5: begin dec_legal = 1'b1; dec_zp = 1'b1; dec_op = OP_SBC; end
      8'h24: begin dec_legal = 1'b1; dec_zp = 1'b1; dec_op = OP_BIT; end
`endif
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and per-state output strobes.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    mem_rd   = 1'b0;
    done     = 1'b0;
    alu_op   = OP_NONE;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept && dec_legal) begin
`ifdef ALU_CTRL_ZP_EN
          state_nx = dec_zp ? FETCH : EXEC;
`else
          state_nx = EXEC;
`endif
        end
      end
`ifdef ALU_CTRL_ZP_EN
      FETCH: begin
        mem_rd   = 1'b1;
        state_nx = WAIT;
      end
      WAIT: state_nx = EXEC;
`endif
      EXEC: begin
        alu_op = op_q;
        if (exec_last) state_nx = WB;
      end
      WB: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Cycles spent in EXEC; restarts whenever EXEC is left.
  always_ff @(posedge clk) begin
    if (rst || state != EXEC) lat_cnt <= '0;
    else                      lat_cnt <= lat_cnt + 1'b1;
  end

  // Instruction latch, operand capture and A/P retirement. A/P are written
  // on the last EXEC edge so the new values are already visible in WB while
  // done is high; a reset on that edge wins and nothing is retired.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= RESET_ACC;
      stat      <= RESET_STATUS;
      illegal_q <= 1'b0;
      op_q      <= OP_NONE;
      opnd_q    <= 8'h00;
    end else begin
      illegal_q <= accept && !dec_legal;
      if (accept && dec_legal) begin
        op_q   <= dec_op;
        opnd_q <= dec_accm ? acc : in_arg;
      end
`ifdef ALU_CTRL_ZP_EN
      if (state == WAIT) opnd_q <= mem_rdata;
`endif
      if (exec_last) begin
        stat <= alu_status_in;
        if (op_q != OP_BIT) acc <= alu_result;
      end
    end
  end

`ifdef ALU_CTRL_ZP_EN
  logic [7:0] arg_q;

  // Zero-page address is held from acceptance; it is only presented in FETCH.
  always_ff @(posedge clk) begin
    if (rst)                       arg_q <= 8'h00;
    else if (accept && dec_legal)  arg_q <= in_arg;
  end

  assign mem_addr = mem_rd ? arg_q : 8'h00;
`else
  logic unused_zp;
  assign unused_zp = ^{mem_rdata, dec_zp};
  assign mem_addr  = 8'h00;
`endif

  assign illegal     = illegal_q;
  assign alu_acc     = acc;
  assign alu_operand = opnd_q;
  assign alu_status  = stat;
  assign acc_out     = acc;
  assign status_out  = stat;

endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: randomized scoreboard bench for alu_ctrl. A stub ALU computes
// an arbitrary opcode-dependent function of its inputs; the reference model
// applies the same function to its own view of A, P and the operand, so any
// wrong operand, op code, status or timing shows up in the retired values.
module tb_alu_ctrl;
  localparam int         LAT  = 1;
  localparam logic [7:0] RACC = 8'h5A;
  localparam logic [7:0] RST  = 8'h24;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] in_opcode, in_arg;
  logic       mem_rd;
  logic [7:0] mem_addr, mem_rdata;
  logic [3:0] alu_op;
  logic [7:0] alu_acc, alu_operand, alu_status, alu_result, alu_status_in;
  logic [7:0] acc_out, status_out;
  logic       done, illegal;

  alu_ctrl #(.ALU_LAT(LAT), .RESET_ACC(RACC), .RESET_STATUS(RST)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_arg(in_arg), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .alu_op(alu_op), .alu_acc(alu_acc),
    .alu_operand(alu_operand), .alu_status(alu_status), .alu_result(alu_result),
    .alu_status_in(alu_status_in), .acc_out(acc_out), .status_out(status_out),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ill;
    logic [3:0] code;
    logic [7:0] acc_pre, opnd, p_pre, acc_exp, p_exp;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] mq[$];
  int         mcq[$];
  logic [7:0] mem [256];
  logic [7:0] m_acc, m_p;
  int         cyc = 0;
  int         checks = 0, errors = 0;

  function automatic logic [7:0] f_res(input logic [3:0] op, input logic [7:0] a, b, p);
    return (a + b + {4'h0, op}) ^ {p[7:4], op};
  endfunction

  function automatic logic [7:0] f_st(input logic [3:0] op, input logic [7:0] a, b);
    return (a ^ {b[6:0], b[7]}) + {op, 4'h0};
  endfunction

  // kind: 0 illegal, 1 immediate, 2 zero-page, 3 accumulator
  function automatic void decode(input logic [7:0] opc, output int kind, output logic [3:0] code);
    kind = 0; code = 4'hF;
    case (opc)
      8'h09: begin kind = 1; code = 4'd5; end
      8'h29: begin kind = 1; code = 4'd3; end
      8'h49: begin kind = 1; code = 4'd4; end
      8'h69: begin kind = 1; code = 4'd1; end
      8'hE9: begin kind = 1; code = 4'd2; end
      8'h0A: begin kind = 3; code = 4'd7; end
      8'h2A: begin kind = 3; code = 4'd9; end
      8'h4A: begin kind = 3; code = 4'd8; end
      8'h6A: begin kind = 3; code = 4'd10; end
`ifdef ALU_CTRL_ZP_EN
      8'h05: begin kind = 2; code = 4'd5; end
      8'h25: begin kind = 2; code = 4'd3; end
      8'h45: begin kind = 2; code = 4'd4; end
      8'h65: begin kind = 2; code = 4'd1; end
      8'hE5: begin kind = 2; code = 4'd2; end
      8'h24: begin kind = 2; code = 4'd6; end
`endif
      default: ;
    endcase
  endfunction

  assign alu_result    = f_res(alu_op, alu_acc, alu_operand, alu_status);
  assign alu_status_in = f_st(alu_op, alu_acc, alu_operand);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT retires or rejects.
  always @(negedge clk) begin
    if (!rst) begin
      chk("done_and_illegal", int'(done && illegal), 0);
      if (mem_rd) begin
        if (mq.size() == 0) chk("mem_rd_unexpected", 1, 0);
        else begin
          chk("mem_addr", mem_addr, mq.pop_front());
          chk("mem_rd_cycle", cyc, mcq.pop_front());
        end
      end
      if (alu_op != 4'hF) begin
        if (sb.size() == 0 || sb[0].ill) chk("alu_op_outside_exec", alu_op, 4'hF);
        else begin
          chk("alu_op", alu_op, sb[0].code);
          chk("alu_acc", alu_acc, sb[0].acc_pre);
          chk("alu_operand", alu_operand, sb[0].opnd);
          chk("alu_status", alu_status, sb[0].p_pre);
          chk("exec_window", int'(cyc >= sb[0].cyc - LAT && cyc < sb[0].cyc), 1);
        end
      end
      if (done || illegal) begin
        if (sb.size() == 0) chk("unexpected_retire", {done, illegal}, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("illegal_flag", illegal, e.ill);
          chk("retire_cycle", cyc, e.cyc);
          chk("acc_out", acc_out, e.acc_exp);
          chk("status_out", status_out, e.p_exp);
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        chk("retire_timeout", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Present one instruction this cycle (in_ready already high) and record
  // what it must do; returns 2 time units after the accept edge.
  task automatic issue(input logic [7:0] opc, input logic [7:0] arg);
    int kind; logic [3:0] code; exp_t e; logic [7:0] r, s;
    in_valid = 1'b1; in_opcode = opc; in_arg = arg;
    decode(opc, kind, code);
    e.ill = (kind == 0); e.code = code;
    e.acc_pre = m_acc; e.p_pre = m_p;
    e.opnd = (kind == 1) ? arg : (kind == 2) ? mem[arg] : m_acc;
    if (kind == 0) e.cyc = cyc + 1;
    else begin
      r = f_res(code, m_acc, e.opnd, m_p);
      s = f_st(code, m_acc, e.opnd);
      m_p = s;
      if (code != 4'd6) m_acc = r;
      e.cyc = cyc + LAT + 1 + ((kind == 2) ? 2 : 0);
      if (kind == 2) begin mq.push_back(arg); mcq.push_back(cyc + 1); end
    end
    e.acc_exp = m_acc; e.p_exp = m_p;
    sb.push_back(e);
    @(posedge clk); #2;
    in_valid = 1'b0; in_opcode = 8'($urandom); in_arg = 8'($urandom);
  endtask

  // Wait for in_ready, toggling garbage on the inputs while busy.
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      in_valid = 1'($urandom); in_opcode = 8'($urandom); in_arg = 8'($urandom);
      @(posedge clk); #2; n++;
    end
    in_valid = 1'b0;
    if (!in_ready) begin
      $display("FAIL ready_timeout: actual 0 required 1");
      $fatal(1, "in_ready never returned");
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_acc"}, acc_out, RACC);
    chk({tag, "_status"}, status_out, RST);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_alu_op"}, alu_op, 4'hF);
    chk({tag, "_strobes"}, {mem_rd, done, illegal}, 0);
  endtask

  logic [7:0] dir_op [6];
  logic [7:0] dir_arg [6];
  logic [7:0] rnd_tab [16];

  initial begin
    dir_op  = '{8'h69, 8'h65, 8'h24, 8'hEA, 8'h05, 8'h0A};
    dir_arg = '{8'h10, 8'h40, 8'h10, 8'h00, 8'h10, 8'h00};
    rnd_tab = '{8'h09, 8'h29, 8'h49, 8'h69, 8'hE9, 8'h05, 8'h25, 8'h45,
                8'h65, 8'hE5, 8'h24, 8'h0A, 8'h2A, 8'h4A, 8'h6A, 8'hEA};
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h40] = 8'h22;
    rst = 1'b1; in_valid = 1'b0; in_opcode = 8'h00; in_arg = 8'h00;
    m_acc = RACC; m_p = RST;
    repeat (2) @(posedge clk);
    #2;
    reset_checks("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wait_ready();
      issue(dir_op[i], dir_arg[i]);
    end

    // Abort mid-instruction: zero-page in WAIT, or immediate in EXEC.
    wait_ready();
`ifdef ALU_CTRL_ZP_EN
    issue(8'h25, 8'h10);
    @(posedge clk); #2;
`else
    issue(8'h29, 8'h10);
`endif
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    sb.delete(); mq.delete(); mcq.delete();
    m_acc = RACC; m_p = RST;
    reset_checks("abort");
    issue(8'h0A, 8'h00);

    for (int i = 0; i < 300; i++) begin
      wait_ready();
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
      end else begin
        int k;
        logic [7:0] opc;
        k = $urandom_range(0, 16);
        opc = (k == 16) ? 8'($urandom) : rnd_tab[k];
        issue(opc, 8'($urandom));
      end
    end

    repeat (20) @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    chk("mem_queue_drained", mq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_ctrl.md
ALU_CTRL -- requirements
Module: alu_ctrl

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, cycles from ALU inputs being driven to alu_result/alu_status_in valid.
REQ-002 SHALL have parameter RESET_ACC, default 8'h00, accumulator value after reset.
REQ-003 SHALL have parameter RESET_STATUS, default 8'h00, status value after reset.
REQ-004 SHALL have ports:
- clk  in  1  the one clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept an instruction.
- in_opcode  in  8  6502 opcode byte.
- in_arg  in  8  immediate value or zero-page address.
- mem_rd  out  1  one-cycle zero-page read strobe.
- mem_addr  out  8  zero-page read address.
- mem_rdata  in  8  read data, valid the cycle after mem_rd.
- alu_op  out  4  ALU op code.
- alu_acc  out  8  ALU accumulator operand.
- alu_operand  out  8  ALU second operand.
- alu_status  out  8  ALU status input.
- alu_result  in  8  ALU result.
- alu_status_in  in  8  ALU status output.
- acc_out  out  8  architectural accumulator A.
- status_out  out  8  architectural status P.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  one-cycle pulse: unsupported opcode rejected.

Function
REQ-005 Status layout: bit7 carry, 6 zero, 5 interrupt_disable, 4 decimal_mode, 3 break_cmd, 2 overflow, 1 negative, 0 unused.
REQ-006 ALU codes: ADD=0 ADC=1 SBC=2 AND=3 EOR=4 ORA=5 BIT=6 ASL=7 LSR=8 ROL=9 ROR=10; alu_op SHALL be 4'hF outside EXEC.
REQ-007 Decode: immediate 09/29/49/69/E9 -> ORA/AND/EOR/ADC/SBC, operand=in_arg; zero-page 05/25/45/65/E5/24 -> ORA/AND/EOR/ADC/SBC/BIT, operand=mem_rdata; accumulator 0A/2A/4A/6A -> ASL/ROL/LSR/ROR, operand=A.
REQ-008 States IDLE, FETCH, WAIT, EXEC, WB; in_ready=1 only in IDLE.
REQ-009 Accept on in_valid&in_ready; opcode and in_arg latched at that edge, later input changes ignored.
REQ-010 IDLE->FETCH for zero-page, ->EXEC for immediate/accumulator, stays IDLE on illegal opcode.
REQ-011 FETCH: mem_rd=1, mem_addr=latched in_arg for exactly one cycle; ->WAIT.
REQ-012 WAIT: mem_rdata captured into operand register at end of cycle; ->EXEC.
REQ-013 EXEC: alu_op, alu_acc=A, alu_operand, alu_status=P held stable ALU_LAT cycles; alu_result/alu_status_in captured on last EXEC edge; ->WB.
REQ-014 WB: P<=captured status for all ops; A<=captured result for all ops except BIT (A unchanged); done=1 this cycle, new A/P visible same cycle; ->IDLE.
REQ-015 Latency accept edge to done cycle: ALU_LAT+1 cycles immediate/accumulator, ALU_LAT+3 zero-page; back-to-back accept possible the cycle after done.
REQ-016 Illegal opcode: illegal=1 the cycle after accept, A/P unchanged, no mem_rd, no done.
REQ-017 done and illegal never both high; mem_rd=0 outside FETCH.

Reset
REQ-018 rst at any edge, including mid-instruction, SHALL abort: state IDLE, acc_out=RESET_ACC, status_out=RESET_STATUS, mem_rd=0, done=0, illegal=0, alu_op=4'hF, in_ready=1 the following cycle.
REQ-019 An instruction aborted by reset SHALL NOT update A or P.

Configuration
REQ-020 Macro ALU_CTRL_ZP_EN defined: zero-page opcodes supported per REQ-007/011/012.
REQ-021 Macro ALU_CTRL_ZP_EN undefined: FETCH/WAIT absent, zero-page opcodes decoded as illegal, mem_rd tied 0, mem_addr tied 8'h00.

Verification
REQ-022 Reset, then 69/10 with ALU model returning 8'h10/8'h00 -> EXEC shows op=1 acc=00 operand=10 status=00; done 2 cycles after accept; acc_out=10.
REQ-023 zp 65/40, mem_rdata=8'h22, model returns 8'h32/8'h00 -> mem_rd one cycle with mem_addr=40; operand=22; done 4 cycles after accept; acc_out=32.
REQ-024 A=8'h81, 24/10, model returns 8'h01/8'h04 -> acc_out stays 81, status_out=04, done pulses.
REQ-025 Opcode 8'hEA -> illegal one cycle, no done, no mem_rd, A/P unchanged, in_ready high next cycle.
REQ-026 rst asserted in WAIT of 25/10 -> no done, acc_out=RESET_ACC, mem_rd=0, in_ready=1 next cycle; following 0A accepted and retired.
REQ-027 Build without ALU_CTRL_ZP_EN, 05/10 -> illegal, mem_rd never asserted.
